// File: rtl/sincos_cordic_iter_pkg.sv
// Shared constants for the iterative sin/cos CORDIC: angle table, gain and
// pi multiples at 16 fractional bits, plus the controller state encoding.
package sincos_cordic_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_ROTATE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // atan(2^-i) * 65536, rounded
    localparam int ATAN16 [16] = '{
        51472, 30386, 16055, 8150, 4091, 2047, 1024, 512,
        256,   128,   64,    32,   16,   8,    4,    2
    };

    localparam int CORDIC_K16 = 39797;
    localparam int PI16       = 205887;
    localparam int HALF_PI16  = 102944;
    localparam int TWO_PI16   = 411775;

    // Re-quantise a 16-fractional-bit constant to f bits, round to nearest.
    function automatic int round_const(input int c16, input int f);
        if (f >= 16) begin
            return c16;
        end
        return (c16 + (1 << (15 - f))) >>> (16 - f);
    endfunction

endpackage

// File: rtl/sincos_range_reduce.sv
// Folds an internal-format angle into [-pi/2, pi/2]; neg flags that the
// rotated result must be negated to compensate for the pi shift.
module sincos_range_reduce
    import sincos_cordic_iter_pkg::*;
#(
    parameter int IW = 14,
    parameter int F  = 8
) (
    input  logic signed [IW-1:0] z_in,
    output logic signed [IW-1:0] z_out,
    output logic                 neg
);

    localparam logic signed [IW-1:0] PI_C      = IW'(round_const(PI16, F));
    localparam logic signed [IW-1:0] HALF_PI_C = IW'(round_const(HALF_PI16, F));
    localparam logic signed [IW-1:0] TWO_PI_C  = IW'(round_const(TWO_PI16, F));

    logic signed [IW-1:0] z_wrap;

    always_comb begin
        z_wrap = z_in;
        if (z_in > PI_C) begin
            z_wrap = z_in - TWO_PI_C;
        end else if (z_in < -PI_C) begin
            z_wrap = z_in + TWO_PI_C;
        end

        z_out = z_wrap;
        neg   = 1'b0;
        if (z_wrap > HALF_PI_C) begin
            z_out = z_wrap - PI_C;
            neg   = 1'b1;
        end else if (z_wrap < -HALF_PI_C) begin
            z_out = z_wrap + PI_C;
            neg   = 1'b1;
        end
    end

endmodule

// File: rtl/sincos_cordic_iter.sv
// Iterative CORDIC sin/cos with range reduction, quadrant folding and a
// valid/ready handshake on each side; one angle in flight at a time.
module sincos_cordic_iter
    import sincos_cordic_iter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 4,
    parameter int GUARD = 4,
    parameter int ITER  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] angle_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sin_out,
    output logic [WIDTH-1:0] cos_out
);

    localparam int IW    = WIDTH + GUARD + 2;
    localparam int F     = FRAC + GUARD;
    localparam int IDX_W = 4;

    generate
        if (F > 16 || ITER < 1 || ITER > F) begin : g_param_check
            $error("sincos_cordic_iter: need FRAC+GUARD <= 16 and 1 <= ITER <= FRAC+GUARD");
        end
    endgenerate

    localparam logic signed [IW-1:0] K_C      = IW'(round_const(CORDIC_K16, F));
    localparam logic signed [IW:0]   HALF_LSB = (IW+1)'((GUARD > 0) ? (1 << (GUARD - 1)) : 0);
    localparam logic signed [IW:0]   MAXV     = (IW+1)'((2 ** (WIDTH - 1)) - 1);
    localparam logic signed [IW:0]   MINV     = -(IW+1)'(2 ** (WIDTH - 1));

    logic signed [IW-1:0] atan_c [16];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_atan
            assign atan_c[gi] = IW'(round_const(ATAN16[gi], F));
        end
    endgenerate

    // Round to nearest at the I/O precision, then clamp to the output range.
    function automatic logic [WIDTH-1:0] sat_round(input logic signed [IW-1:0] v);
        logic signed [IW:0] t;
        t = (IW+1)'(v) + HALF_LSB;
        t = t >>> GUARD;
        if (t > MAXV) begin
            t = MAXV;
        end else if (t < MINV) begin
            t = MINV;
        end
        return t[WIDTH-1:0];
    endfunction

    state_t               state_reg, state_next;
    logic signed [IW-1:0] x_reg, x_next;
    logic signed [IW-1:0] y_reg, y_next;
    logic signed [IW-1:0] z_reg, z_next;
    logic                 neg_reg, neg_next;
    logic [IDX_W-1:0]     i_reg, i_next;
    logic [WIDTH-1:0]     sin_reg, sin_next;
    logic [WIDTH-1:0]     cos_reg, cos_next;

    logic signed [IW-1:0] red_z;
    logic                 red_neg;
    logic                 d_pos;
    logic signed [IW-1:0] x_rot, y_rot, z_rot;

    sincos_range_reduce #(.IW(IW), .F(F)) u_reduce (
        .z_in  (z_reg),
        .z_out (red_z),
        .neg   (red_neg)
    );

    // z == 0 rotates in the positive direction
    assign d_pos = !z_reg[IW-1];
    assign x_rot = d_pos ? (x_reg - (y_reg >>> i_reg)) : (x_reg + (y_reg >>> i_reg));
    assign y_rot = d_pos ? (y_reg + (x_reg >>> i_reg)) : (y_reg - (x_reg >>> i_reg));
    assign z_rot = d_pos ? (z_reg - atan_c[i_reg])     : (z_reg + atan_c[i_reg]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            neg_reg   <= 1'b0;
            i_reg     <= '0;
            sin_reg   <= '0;
            cos_reg   <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            z_reg     <= z_next;
            neg_reg   <= neg_next;
            i_reg     <= i_next;
            sin_reg   <= sin_next;
            cos_reg   <= cos_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        z_next     = z_reg;
        neg_next   = neg_reg;
        i_next     = i_reg;
        sin_next   = sin_reg;
        cos_next   = cos_reg;

        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    z_next     = {{(GUARD + 2){angle_in[WIDTH-1]}}, angle_in} <<< GUARD;
                    state_next = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                z_next     = red_z;
                neg_next   = red_neg;
                x_next     = K_C;
                y_next     = '0;
                i_next     = '0;
                state_next = ST_ROTATE;
            end
            ST_ROTATE: begin
                x_next = x_rot;
                y_next = y_rot;
                z_next = z_rot;
                i_next = i_reg + IDX_W'(1);
                // Results are latched here so they survive the next REDUCE.
                if (i_reg == IDX_W'(ITER - 1)) begin
                    sin_next   = sat_round(neg_reg ? -y_rot : y_rot);
                    cos_next   = sat_round(neg_reg ? -x_rot : x_rot);
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign sin_out   = sin_reg;
    assign cos_out   = cos_reg;

endmodule
